// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter sharing one registered write port among NREQ requesters.
// Grants are registered and one-hot; each grant is bounded by MAX_HOLD when contended.
module reg_port_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic                    port_we,
    output logic [WIDTH-1:0]        port_d,
    output logic                    busy,
    output logic                    preempt
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    owner;
    logic [HW-1:0]    hold_cnt;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    next_ptr;
    logic             owner_req;
    logic             competitor;
    logic [WIDTH-1:0] owner_d;

    always_comb begin
        int idx;
        idx = 0;
        sel = '0;
        // Scan from the far end back toward ptr so the index closest to ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) sel = IW'(idx);
        end
        next_ptr   = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
        owner_req  = req[owner];
        owner_d    = wdata[int'(owner)*WIDTH +: WIDTH];
        // gnt holds only the owner bit while in GRANT.
        competitor = |(req & ~gnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            port_we  <= 1'b0;
            port_d   <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    port_we <= 1'b0;
                    if (|req) begin
                        gnt      <= '0;
                        gnt[sel] <= 1'b1;
                        owner    <= sel;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    port_we <= owner_req;
                    if (owner_req) port_d <= owner_d;
                    // The write sampled on a preempting edge is still issued above.
                    if (!owner_req || (hold_cnt == HOLD_LAST && competitor)) begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                        ptr     <= next_ptr;
                        preempt <= owner_req;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a tenure-based model.
module tb_reg_port_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*W-1:0]   wdata;
    logic [N-1:0]     gnt;
    logic             port_we;
    logic [W-1:0]     port_d;
    logic             busy;
    logic             preempt;

    reg_port_arbiter #(.NREQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata),
        .gnt(gnt), .port_we(port_we), .port_d(port_d), .busy(busy), .preempt(preempt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: who owns the port, for how many cycles, and where the next scan starts.
    int           m_owner = -1;
    int           m_ptr   = 0;
    int           m_ten   = 0;
    logic         m_we    = 1'b0;
    logic         m_pre   = 1'b0;
    logic [W-1:0] m_d     = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit others;
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_ten = 0; m_we = 0; m_pre = 0; m_d = '0;
        end else if (m_owner < 0) begin
            m_we = 0; m_pre = 0;
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_ten   = 1;
                end
            end
        end else begin
            m_pre  = 0;
            m_we   = req[m_owner];
            if (req[m_owner]) m_d = wdata[m_owner*W +: W];
            others = 0;
            for (int k = 0; k < N; k++) if (k != m_owner && req[k]) others = 1;
            if (!req[m_owner]) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1;
            end else if (m_ten >= MH && others) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_pre = 1;
            end else begin
                m_ten++;
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d);
        logic [N-1:0] eg;
        reset = r; req = q; wdata = d;
        @(posedge clk);
        #1;
        model_step();
        eg = (m_owner < 0) ? '0 : N'(1) << m_owner;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("port_we", 32'(port_we), 32'(m_we));
        chk("port_d", 32'(port_d), 32'(m_d));
        chk("preempt", 32'(preempt), 32'(m_pre));
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    initial begin
        logic [N-1:0]   rq;
        logic [N-1:0]   prev;
        logic [N*W-1:0] d;
        logic [N-1:0]   order [$];
        int             writes;
        int             pres;
        int             held;

        // Reset state
        step(1'b1, '0, '0);
        step(1'b1, '0, '0);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_port_d", 32'(port_d), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // Single request from requester 1 with 0x5A, three writes
        d = rnd_data(); d[1*W +: W] = 8'h5A;
        step(1'b0, 4'b0010, d);
        chk("single_gnt", 32'(gnt), 32'h2);
        chk("single_we_gap", 32'(port_we), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0010, d);
            chk("single_we", 32'(port_we), 32'h1);
            chk("single_d", 32'(port_d), 32'h5A);
        end
        step(1'b0, 4'b0000, rnd_data());
        chk("single_rel_gnt", 32'(gnt), 32'h0);
        chk("single_rel_busy", 32'(busy), 32'h0);
        chk("single_hold_d", 32'(port_d), 32'h5A);

        // Reset mid-grant: requester 2 writing, then reset with req 1 and 2 pending
        step(1'b0, 4'b0100, rnd_data());
        chk("mid_gnt", 32'(gnt), 32'h4);
        step(1'b0, 4'b0100, rnd_data());
        chk("mid_we", 32'(port_we), 32'h1);
        step(1'b1, 4'b0110, rnd_data());
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_we", 32'(port_we), 32'h0);
        chk("mid_rst_d", 32'(port_d), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        step(1'b0, 4'b0110, rnd_data());
        chk("post_rst_gnt", 32'(gnt), 32'h2);

        // Round-robin fairness from ptr=0 with all requesting
        step(1'b1, '0, '0);
        prev = '0; writes = 0; pres = 0;
        for (int i = 0; i < 21; i++) begin
            step(1'b0, 4'b1111, rnd_data());
            if (gnt != 0 && prev == 0) order.push_back(gnt);
            prev = gnt;
            writes += int'(port_we);
            pres   += int'(preempt);
        end
        chk("rr_count", 32'(order.size()), 32'd5);
        if (order.size() == 5) begin
            chk("rr_0", 32'(order[0]), 32'h1);
            chk("rr_1", 32'(order[1]), 32'h2);
            chk("rr_2", 32'(order[2]), 32'h4);
            chk("rr_3", 32'(order[3]), 32'h8);
            chk("rr_4", 32'(order[4]), 32'h1);
        end
        chk("rr_writes", 32'(writes), 32'd16);
        chk("rr_preempts", 32'(pres), 32'd4);
        step(1'b0, 4'b0000, rnd_data());

        // Wrap-around: grant 2 then release leaves ptr=3
        step(1'b0, 4'b0100, rnd_data());
        step(1'b0, 4'b0000, rnd_data());
        step(1'b0, 4'b0001, rnd_data());
        chk("wrap_gnt0", 32'(gnt), 32'h1);
        step(1'b0, 4'b0000, rnd_data());
        step(1'b0, 4'b1001, rnd_data());
        chk("wrap_gnt3", 32'(gnt), 32'h8);
        step(1'b0, 4'b0000, rnd_data());

        // No competitor: owner holds past MAX_HOLD
        step(1'b0, 4'b0100, rnd_data());
        writes = 0; pres = 0; held = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'b0100, rnd_data());
            writes += int'(port_we);
            pres   += int'(preempt);
            held   += int'(gnt == 4'b0100);
        end
        chk("solo_writes", 32'(writes), 32'd10);
        chk("solo_preempts", 32'(pres), 32'd0);
        chk("solo_held", 32'(held), 32'd10);
        step(1'b0, 4'b0000, rnd_data());

        // Owner drop with a competitor arriving the same cycle (ptr=3 here)
        step(1'b0, 4'b0001, rnd_data());
        chk("drop_gnt0", 32'(gnt), 32'h1);
        step(1'b0, 4'b0001, rnd_data());
        step(1'b0, 4'b0010, rnd_data());
        chk("drop_gap_gnt", 32'(gnt), 32'h0);
        chk("drop_gap_we", 32'(port_we), 32'h0);
        step(1'b0, 4'b0010, rnd_data());
        chk("drop_next_gnt", 32'(gnt), 32'h2);
        step(1'b0, 4'b0000, rnd_data());

        // Randomized traffic with sticky requests and occasional reset
        rq = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) rq = N'($urandom);
            step(($urandom_range(0, 59) == 0), rq, rnd_data());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_port_arbiter.md
Name: reg_port_arbiter

Overview:
- Shares one registered write port (data register plus write enable) among NREQ requesters in the microprocessor datapath, e.g. a fetch unit, an ALU writeback and a debug loader.
- Round-robin arbitration with a bounded hold time.
- Registered one-hot grant.
- Registered output data/enable, so the port drives a WIDTH-bit storage register directly.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, data width of each requester and of the shared port
MAX_HOLD, 4, grant cycles after which the owner is preempted if another requester is pending (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the rising clk edge where it is high
req  input  NREQ  per-requester request; held high while the requester wants to write
wdata  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  registered one-hot grant (all-zero when idle)
port_we  output  1  registered write enable of the shared port
port_d  output  WIDTH  registered write data of the shared port
busy  output  1  high while in GRANT state
preempt  output  1  one-cycle pulse when a grant is removed by the hold limit

Behaviour:
- Reset values: gnt=0, port_we=0, port_d=0, busy=0, preempt=0, state=IDLE, round-robin pointer ptr=0, hold_cnt=0. Reset wins over all other events, including mid-grant; the outputs are zero on the cycle after the reset edge.
- States: IDLE, GRANT.
- IDLE:
  - If any req bit is high, select the first requester at index ptr, ptr+1, ... with wrap modulo NREQ.
  - On the edge: gnt[sel]=1, owner=sel, hold_cnt=0, state=GRANT.
  - Latency from req to gnt is 1 cycle.
  - If req==0, stay in IDLE; outputs stay 0.
- GRANT, every cycle:
  - Data path: port_we <= req[owner]; port_d <= wdata[owner] when req[owner]=1, else port_d holds its value. Data appears 1 cycle after it is sampled under gnt.
  - Release by owner: if req[owner]=0, then on the edge gnt<=0, state=IDLE, ptr<=(owner+1) mod NREQ, port_we<=0.
  - Preemption: if req[owner]=1, hold_cnt==MAX_HOLD-1 and any other req bit is high, then on the edge:
    - gnt<=0, state=IDLE, ptr<=(owner+1) mod NREQ, preempt<=1 for one cycle;
    - the write sampled this cycle is still issued (port_we<=1).
  - Otherwise hold_cnt increments, saturating at MAX_HOLD-1. With no competitor the owner holds indefinitely.
- Turnaround: each release or preemption returns through IDLE. gnt is all-zero for exactly one cycle between consecutive grants, so there is no back-to-back grant.
- Write count: a preempted grant performs exactly MAX_HOLD writes.
- Requests in IDLE that drop before being sampled are ignored; there is no request latching.
- Requests from non-owners during GRANT are not queued. They are only seen at the next IDLE evaluation.
- Invariants:
  - gnt is one-hot or zero at all times.
  - busy == (gnt != 0).
  - port_we is never high two cycles after gnt dropped.
- Assumption: wdata of non-owners is don't-care.

Test Plan:
- Reset mid-grant: requester 2 granted and writing, reset pulsed for 1 cycle -> the next cycle shows gnt=0, port_we=0, port_d=0, busy=0. With req[1] and req[2] high after reset, the first grant goes to 1 (ptr=0).
- Single request: req=4'b0010 with wdata[1]=0x5A held 3 cycles, then dropped:
  - gnt=0010 one cycle after req;
  - port_we=1 with port_d=0x5A for 3 consecutive cycles starting one cycle after gnt;
  - then gnt=0, busy=0, port_d stays 0x5A.
- Round-robin fairness: req=4'b1111 held constant, MAX_HOLD=4 -> grant order 0,1,2,3,0; each grant lasts 4 cycles followed by 1 idle cycle; preempt pulses 4 times; 4 writes per grant.
- Wrap-around: ptr=3 after a grant to requester 2, then req=4'b0001 -> gnt=0001. After release, req=4'b1001 -> gnt=1000.
- No competitor: req=4'b0100 held 10 cycles -> gnt stays 0100 for all 10 cycles, preempt never asserts, 10 writes issued.
- Owner drop plus competitor: requester 0 granted, req=4'b0010 on the cycle req[0] falls -> gnt=0 for one cycle, then gnt=0010. port_we=0 in the gap cycle.
